// File: rtl/alu_nibble_seq_if.sv
// Request/result bundle between a requester and the nibble-serial ALU sequencer.
interface alu_nibble_seq_if #(
   parameter int N = 4
) ();
   localparam int W = 4 * N;

   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [2:0]   Op;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] R;
   logic         zero;
   logic         carry;
   logic         sign;

   modport master (
      output start, A, B, Op, c_in,
      input  busy, done, R, zero, carry, sign
   );

   modport slave (
      input  start, A, B, Op, c_in,
      output busy, done, R, zero, carry, sign
   );
endinterface

// File: rtl/alu_nibble_seq.sv
// 4-bit ALU slice plus a sequencer that runs it over N nibbles, LSB first,
// chaining carry through a register and merging full-width flags at the end.

// 4-bit ALU. Op[2]=0: arithmetic with carry; Op[2]=1: bitwise logic, carry 0.
//   000 a+b+ci   001 a+~b+ci   010 a+ci   011 a+4'hF+ci
//   100 a&b      101 a|b       110 a^b    111 ~a
module alu (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [2:0] op,
   input  logic       c_in,
   output logic [3:0] r,
   output logic       c_out
);
   logic [4:0] sum;

   // Combinational nibble result and carry-out.
   always_comb begin
      sum   = 5'd0;
      r     = 4'd0;
      c_out = 1'b0;
      case (op[1:0])
         2'd0:    sum = {1'b0, a} + {1'b0, b} + {4'd0, c_in};
         2'd1:    sum = {1'b0, a} + {1'b0, ~b} + {4'd0, c_in};
         2'd2:    sum = {1'b0, a} + {4'd0, c_in};
         default: sum = {1'b0, a} + 5'h0F + {4'd0, c_in};
      endcase
      if (op[2]) begin
         case (op[1:0])
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = ~a;
         endcase
      end else begin
         r     = sum[3:0];
         c_out = sum[4];
      end
   end
endmodule

module alu_nibble_seq #(
   parameter int N = 4
) (
   input logic             clk,
   input logic             reset,
   alu_nibble_seq_if.slave bus
);
   localparam int W     = 4 * N;
   localparam int IDX_W = $clog2(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [2:0]         op_q, op_d;
   logic               cin_q, cin_d;
   logic               cy_q, cy_d;
   logic [W-1:0]       r_q, r_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               sign_q, sign_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [3:0]         alu_a;
   logic [3:0]         alu_b;
   logic               alu_cin;
   logic [3:0]         alu_r;
   logic               alu_cout;

   alu u_alu (
      .a     (alu_a),
      .b     (alu_b),
      .op    (op_q),
      .c_in  (alu_cin),
      .r     (alu_r),
      .c_out (alu_cout)
   );

   // Operand nibble select and carry source for the nibble currently in flight.
   always_comb begin
      alu_a = 4'd0;
      alu_b = 4'd0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IDX_W'(i)) begin
            alu_a = a_q[4*i +: 4];
            alu_b = b_q[4*i +: 4];
         end
      end
      alu_cin = (idx_q == '0) ? cin_q : cy_q;
   end

   // Next-state: accept in IDLE, one nibble per RUN cycle, flags merged on entry to DONE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      cin_d   = cin_q;
      cy_d    = cy_q;
      r_d     = r_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      sign_d  = sign_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.A;
               b_d     = bus.B;
               op_d    = bus.Op;
               cin_d   = bus.c_in;
               idx_d   = '0;
               r_d     = '0;
               zero_d  = 1'b0;
               carry_d = 1'b0;
               sign_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < N; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  r_d[4*i +: 4] = alu_r;
               end
            end
            cy_d = alu_cout;
            if (idx_q == IDX_W'(N - 1)) begin
               // Flags come from the assembled word, never from per-nibble status.
               zero_d  = ~|r_d;
               sign_d  = r_d[W-1];
               carry_d = ~op_q[2] & alu_cout;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               idx_d  = idx_q + 1'b1;
               busy_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control, result and flag registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cy_q    <= 1'b0;
         r_q     <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         sign_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cy_q    <= cy_d;
         r_q     <= r_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         sign_q  <= sign_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Latched operands; only meaningful once an operation has been accepted.
   always_ff @(posedge clk) begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      cin_q <= cin_d;
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.R     = r_q;
   assign bus.zero  = zero_q;
   assign bus.carry = carry_q;
   assign bus.sign  = sign_q;
endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: an N=4 and an N=2 instance against a full-width
// arithmetic model, plus directed literal expectations.
module tb_alu_nibble_seq;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_nibble_seq_if #(.N(4)) if4 ();
   alu_nibble_seq_if #(.N(2)) if2 ();

   alu_nibble_seq #(.N(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
   alu_nibble_seq #(.N(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));

   logic        start_v [2];
   logic [31:0] a_v     [2];
   logic [31:0] b_v     [2];
   logic [2:0]  op_v    [2];
   logic        cin_v   [2];

   assign if4.start = start_v[0];
   assign if4.A     = a_v[0][15:0];
   assign if4.B     = b_v[0][15:0];
   assign if4.Op    = op_v[0];
   assign if4.c_in  = cin_v[0];
   assign if2.start = start_v[1];
   assign if2.A     = a_v[1][7:0];
   assign if2.B     = b_v[1][7:0];
   assign if2.Op    = op_v[1];
   assign if2.c_in  = cin_v[1];

   logic        busy_o [2];
   logic        done_o [2];
   logic [31:0] r_o    [2];
   logic        zero_o [2];
   logic        carry_o[2];
   logic        sign_o [2];

   assign busy_o[0]  = if4.busy;
   assign done_o[0]  = if4.done;
   assign r_o[0]     = 32'(if4.R);
   assign zero_o[0]  = if4.zero;
   assign carry_o[0] = if4.carry;
   assign sign_o[0]  = if4.sign;
   assign busy_o[1]  = if2.busy;
   assign done_o[1]  = if2.done;
   assign r_o[1]     = 32'(if2.R);
   assign zero_o[1]  = if2.zero;
   assign carry_o[1] = if2.carry;
   assign sign_o[1]  = if2.sign;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int nn(input int d);
      return (d == 0) ? 4 : 2;
   endfunction

   // Whole-word reference: {carry, result} for a W=4n-bit operation.
   function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic ci, input int n);
      logic [63:0] m, aa, bb, s;
      int w;
      w  = 4 * n;
      m  = (64'd1 << w) - 64'd1;
      aa = {32'd0, a} & m;
      bb = {32'd0, b} & m;
      case (op)
         3'd0:    s = aa + bb + 64'(ci);
         3'd1:    s = aa + (~bb & m) + 64'(ci);
         3'd2:    s = aa + 64'(ci);
         3'd3:    s = aa + m + 64'(ci);
         3'd4:    s = aa & bb;
         3'd5:    s = aa | bb;
         3'd6:    s = aa ^ bb;
         default: s = ~aa & m;
      endcase
      return {(op[2] ? 1'b0 : s[w]), s[31:0] & m[31:0]};
   endfunction

   // Expected-output model: phase 0 idle, 1 computing, 2 result pulse.
   int          ph    [2];
   int          cnt   [2];
   logic [32:0] pend  [2];
   logic [31:0] e_r   [2];
   logic        e_z   [2];
   logic        e_c   [2];
   logic        e_s   [2];
   logic        e_busy[2];
   logic        e_done[2];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            ph[d] <= 0; cnt[d] <= 0; e_r[d] <= '0; e_z[d] <= 1'b0; e_c[d] <= 1'b0;
            e_s[d] <= 1'b0; e_busy[d] <= 1'b0; e_done[d] <= 1'b0;
         end else begin
            case (ph[d])
               0: if (start_v[d]) begin
                  ph[d] <= 1; cnt[d] <= 0;
                  pend[d] <= golden(a_v[d], b_v[d], op_v[d], cin_v[d], nn(d));
                  e_r[d] <= '0; e_z[d] <= 1'b0; e_c[d] <= 1'b0; e_s[d] <= 1'b0;
                  e_busy[d] <= 1'b1;
               end
               1: begin
                  if (cnt[d] + 1 == nn(d)) begin
                     ph[d] <= 2; e_busy[d] <= 1'b0; e_done[d] <= 1'b1;
                     e_r[d] <= pend[d][31:0];
                     e_z[d] <= (pend[d][31:0] == 32'd0);
                     e_c[d] <= pend[d][32];
                     e_s[d] <= pend[d][4*nn(d)-1];
                  end else begin
                     cnt[d] <= cnt[d] + 1;
                     e_r[d] <= pend[d][31:0] & ((32'd1 << (4 * (cnt[d] + 1))) - 32'd1);
                  end
               end
               default: begin
                  ph[d] <= 0; e_done[d] <= 1'b0;
               end
            endcase
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("busy[%0d]", d),  32'(busy_o[d]),  32'(e_busy[d]));
            check($sformatf("done[%0d]", d),  32'(done_o[d]),  32'(e_done[d]));
            check($sformatf("R[%0d]", d),     r_o[d],          e_r[d]);
            check($sformatf("zero[%0d]", d),  32'(zero_o[d]),  32'(e_z[d]));
            check($sformatf("carry[%0d]", d), 32'(carry_o[d]), 32'(e_c[d]));
            check($sformatf("sign[%0d]", d),  32'(sign_o[d]),  32'(e_s[d]));
         end
      end
   end

   // Returns k = index of the edge after which done was first seen (accept edge = 0).
   task automatic wait_done(input int d, output int k);
      k = 0;
      while (!done_o[d] && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) check($sformatf("done_timeout[%0d]", d), 32'(k), 32'(nn(d)));
   endtask

   task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic ci, output int k);
      @(negedge clk);
      a_v[d] = a; b_v[d] = b; op_v[d] = op; cin_v[d] = ci; start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      a_v[d] = $urandom; b_v[d] = $urandom;
      op_v[d] = 3'($urandom); cin_v[d] = 1'($urandom);
      wait_done(d, k);
   endtask

   initial begin
      int k;
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0; op_v[d] = '0; cin_v[d] = 1'b0;
      end
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset_R", r_o[0], 32'h0);
      check("reset_busy", 32'(busy_o[0]), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // ADD, no overflow
      do_op(0, 32'h1234, 32'h0FFF, 3'd0, 1'b0, k);
      check("add_done_edge", 32'(k), 32'd4);
      check("add_R", r_o[0], 32'h2233);
      check("add_carry", 32'(carry_o[0]), 32'h0);
      check("add_zero", 32'(zero_o[0]), 32'h0);
      check("add_sign", 32'(sign_o[0]), 32'h0);

      // ADD with full ripple
      do_op(0, 32'hFFFF, 32'h0001, 3'd0, 1'b0, k);
      check("ripple_R", r_o[0], 32'h0000);
      check("ripple_zero", 32'(zero_o[0]), 32'h1);
      check("ripple_carry", 32'(carry_o[0]), 32'h1);
      check("ripple_sign", 32'(sign_o[0]), 32'h0);

      // Logic AND
      do_op(0, 32'hF0F0, 32'h8000, 3'd4, 1'b1, k);
      check("and_R", r_o[0], 32'h8000);
      check("and_carry", 32'(carry_o[0]), 32'h0);
      check("and_sign", 32'(sign_o[0]), 32'h1);

      // N=2 subtract without borrow
      do_op(1, 32'h9C, 32'h75, 3'd1, 1'b1, k);
      check("sub2_done_edge", 32'(k), 32'd2);
      check("sub2_R", r_o[1], 32'h27);
      check("sub2_carry", 32'(carry_o[1]), 32'h1);

      // Start held through RUN with other operands is ignored
      @(negedge clk);
      a_v[0] = 32'h0100; b_v[0] = 32'h0200; op_v[0] = 3'd0; cin_v[0] = 1'b0; start_v[0] = 1'b1;
      @(negedge clk);
      a_v[0] = 32'hFFFF; b_v[0] = 32'hFFFF;
      @(negedge clk);
      start_v[0] = 1'b0;
      wait_done(0, k);
      check("ign_R", r_o[0], 32'h0300);
      repeat (3) @(negedge clk);
      check("ign_hold_R", r_o[0], 32'h0300);
      check("ign_no_busy", 32'(busy_o[0]), 32'h0);
      do_op(0, 32'hAAAA, 32'h5555, 3'd6, 1'b0, k);
      check("xor_done_edge", 32'(k), 32'd4);
      check("xor_R", r_o[0], 32'hFFFF);
      check("xor_sign", 32'(sign_o[0]), 32'h1);

      // Reset mid-RUN aborts with no done
      @(negedge clk);
      a_v[0] = 32'h1111; b_v[0] = 32'h2222; op_v[0] = 3'd0; cin_v[0] = 1'b0; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy_o[0]), 32'h0);
      check("abort_R", r_o[0], 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done_o[0]), 32'h0);
      end

      // Random sweeps
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 1000; i++) begin
            do_op(d, $urandom, $urandom, 3'($urandom), 1'($urandom), k);
         end
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
